// File: rtl/ppc_pkg.sv
// Shared types for the F/D/E/WB pipeline sequencer: states, stage indices, PC widths.
// Pure declarations; no timing or flow control of its own.
package ppc_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    BUBBLE = 2'd1,
    HALTED = 2'd2
  } state_e;

  localparam int STG_F  = 0;
  localparam int STG_D  = 1;
  localparam int STG_E  = 2;
  localparam int STG_WB = 3;

  localparam int PC_W = 64;
  localparam int DW_W = 61;

  typedef logic [0:PC_W-1] pc_t;
  typedef logic [0:DW_W-1] dw_addr_t;

  localparam pc_t INSTR_BYTES = 64'd4;

  // Big-endian bit numbering: [0:60] is the doubleword address of a byte PC.
  function automatic dw_addr_t dw_addr(input pc_t p);
    return p[0:DW_W-1];
  endfunction

endpackage

// File: rtl/ppc_pipe_ctrl_if.sv
// Datapath <-> sequencer bundle: WB-stage events in, fetch/stage PCs, valids and perf counters out.
// Level signals sampled every cycle; stall_req is the only backpressure.
interface ppc_pipe_ctrl_if #(
  parameter int unsigned CNT_W = 32
);
  import ppc_pkg::*;

  logic             stall_req;
  logic             branch_taken_wb;
  pc_t              branch_target;
  logic             st_en_wb;
  dw_addr_t         st_addr_wb;
  logic             halt_req;

  pc_t              pc;
  pc_t              pc_d;
  pc_t              pc_e;
  pc_t              pc_wb;
  logic             valid_d;
  logic             valid_e;
  logic             valid_wb;
  logic             halted;
  logic [CNT_W-1:0] cycle_cnt;
  logic [CNT_W-1:0] retired_cnt;
  logic [CNT_W-1:0] redirect_cnt;

  modport master (
    output stall_req, branch_taken_wb, branch_target, st_en_wb, st_addr_wb, halt_req,
    input  pc, pc_d, pc_e, pc_wb, valid_d, valid_e, valid_wb, halted,
    input  cycle_cnt, retired_cnt, redirect_cnt
  );

  modport slave (
    input  stall_req, branch_taken_wb, branch_target, st_en_wb, st_addr_wb, halt_req,
    output pc, pc_d, pc_e, pc_wb, valid_d, valid_e, valid_wb, halted,
    output cycle_cnt, retired_cnt, redirect_cnt
  );

endinterface

// File: rtl/ppc_sat_counter.sv
// Saturating event counter: value increments on inc and sticks at all-ones.
// One-cycle update latency; synchronous active-high reset clears it.
module ppc_sat_counter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [WIDTH-1:0] value
);

  always_ff @(posedge clk) begin
    if (reset) begin
      value <= '0;
    end else if (inc && (value != '1)) begin
      value <= value + WIDTH'(1);
    end
  end

endmodule

// File: rtl/ppc_pipe_ctrl.sv
// Sequencer for the 4-stage F/D/E/WB pipeline: fetch PC, stage PCs/valids, WB redirects and halt.
// WB events take effect at the next edge; stall_req freezes every stage unless a WB event fires.
module ppc_pipe_ctrl
  import ppc_pkg::*;
#(
  parameter pc_t         RESET_PC         = 64'h0,
  parameter int unsigned REDIRECT_BUBBLES = 0,
  parameter int unsigned CNT_W            = 32
) (
  input  logic           clk,
  input  logic           reset,
  ppc_pipe_ctrl_if.slave bus
);

  localparam logic [3:0] BUB_INIT = 4'(REDIRECT_BUBBLES);

  state_e            r_state;
  state_e            w_state_nxt;
  logic [3:0]        r_bub_cnt;
  logic [3:0]        w_bub_cnt_nxt;

  pc_t               r_pc;
  pc_t               r_pc_d;
  pc_t               r_pc_e;
  pc_t               r_pc_wb;
  pc_t               w_target;
  logic              r_vld_d;
  logic              r_vld_e;
  logic              r_vld_wb;
  logic [STG_F:STG_WB] w_vld;

  logic              w_halted;
  logic              w_halt;
  logic              w_branch;
  logic              w_hit_e;
  logic              w_hit_d;
  logic              w_hit_f;
  logic              w_hazard;
  logic              w_redirect;
  logic              w_advance;
  logic              w_retire;

  logic [CNT_W-1:0]  w_cycle_cnt;
  logic [CNT_W-1:0]  w_retired_cnt;
  logic [CNT_W-1:0]  w_redirect_cnt;

  assign w_halted = (r_state == HALTED);
  assign w_vld    = {(r_state == RUN), r_vld_d, r_vld_e, r_vld_wb};

  // Only younger instructions can hold stale code; WB itself is the store.
  assign w_hit_e = w_vld[STG_E] && (dw_addr(r_pc_e) == bus.st_addr_wb);
  assign w_hit_d = w_vld[STG_D] && (dw_addr(r_pc_d) == bus.st_addr_wb);
  assign w_hit_f = w_vld[STG_F] && (dw_addr(r_pc)   == bus.st_addr_wb);

  assign w_halt     = w_vld[STG_WB] && bus.halt_req;
  assign w_branch   = w_vld[STG_WB] && bus.branch_taken_wb && !bus.halt_req;
  assign w_hazard   = w_vld[STG_WB] && bus.st_en_wb && !bus.halt_req && !bus.branch_taken_wb &&
                      (w_hit_e || w_hit_d || w_hit_f);
  assign w_redirect = w_branch || w_hazard;
  assign w_advance  = !w_halted && !bus.stall_req;
  assign w_retire   = r_vld_wb && (w_halt || w_redirect || !bus.stall_req);

  always_comb begin
    w_target = r_pc;
    if (w_branch) begin
      w_target = bus.branch_target;
    end else if (w_hit_e) begin
      w_target = r_pc_e;
    end else if (w_hit_d) begin
      w_target = r_pc_d;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_bub_cnt_nxt = r_bub_cnt;
    case (r_state)
      RUN, BUBBLE: begin
        if (w_halt) begin
          w_state_nxt = HALTED;
        end else if (w_redirect) begin
          if (REDIRECT_BUBBLES != 0) begin
            w_state_nxt   = BUBBLE;
            w_bub_cnt_nxt = BUB_INIT;
          end else begin
            w_state_nxt = RUN;
          end
        end else if ((r_state == BUBBLE) && !bus.stall_req) begin
          if (r_bub_cnt <= 4'd1) begin
            w_state_nxt   = RUN;
            w_bub_cnt_nxt = 4'd0;
          end else begin
            w_bub_cnt_nxt = r_bub_cnt - 4'd1;
          end
        end
      end
      HALTED: begin
        w_state_nxt = HALTED;
      end
      default: begin
        w_state_nxt   = RUN;
        w_bub_cnt_nxt = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= RUN;
      r_bub_cnt <= 4'd0;
    end else begin
      r_state   <= w_state_nxt;
      r_bub_cnt <= w_bub_cnt_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc     <= RESET_PC;
      r_pc_d   <= '0;
      r_pc_e   <= '0;
      r_pc_wb  <= '0;
      r_vld_d  <= 1'b0;
      r_vld_e  <= 1'b0;
      r_vld_wb <= 1'b0;
    end else if (w_halt) begin
      r_vld_d  <= 1'b0;
      r_vld_e  <= 1'b0;
      r_vld_wb <= 1'b0;
    end else if (w_redirect) begin
      r_pc     <= w_target;
      r_pc_d   <= r_pc;
      r_pc_e   <= r_pc_d;
      r_pc_wb  <= r_pc_e;
      r_vld_d  <= 1'b0;
      r_vld_e  <= 1'b0;
      r_vld_wb <= 1'b0;
    end else if (w_advance) begin
      if (w_vld[STG_F]) begin
        r_pc <= r_pc + INSTR_BYTES;
      end
      r_pc_d   <= r_pc;
      r_pc_e   <= r_pc_d;
      r_pc_wb  <= r_pc_e;
      r_vld_d  <= w_vld[STG_F];
      r_vld_e  <= r_vld_d;
      r_vld_wb <= r_vld_e;
    end
  end

  ppc_sat_counter #(.WIDTH(CNT_W)) u_cycle_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (!w_halted),
    .value (w_cycle_cnt)
  );

  ppc_sat_counter #(.WIDTH(CNT_W)) u_retired_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (w_retire),
    .value (w_retired_cnt)
  );

  ppc_sat_counter #(.WIDTH(CNT_W)) u_redirect_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (w_redirect),
    .value (w_redirect_cnt)
  );

  assign bus.pc           = r_pc;
  assign bus.pc_d         = r_pc_d;
  assign bus.pc_e         = r_pc_e;
  assign bus.pc_wb        = r_pc_wb;
  assign bus.valid_d      = r_vld_d;
  assign bus.valid_e      = r_vld_e;
  assign bus.valid_wb     = r_vld_wb;
  assign bus.halted       = w_halted;
  assign bus.cycle_cnt    = w_cycle_cnt;
  assign bus.retired_cnt  = w_retired_cnt;
  assign bus.redirect_cnt = w_redirect_cnt;

endmodule

// File: tb/tb_ppc_pipe_ctrl.sv
// Directed bench: u0 default params, u1 with two redirect bubbles, u2 with wrap-around reset PC and 4-bit counters.
// Retirement stream of u0 is checked by a scoreboard; state is checked directly per cycle.
module tb_ppc_pipe_ctrl;
  import ppc_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [63:0] exp_q[$];
  logic [63:0] mon_exp;

  ppc_pipe_ctrl_if #(.CNT_W(32)) b0 ();
  ppc_pipe_ctrl_if #(.CNT_W(32)) b1 ();
  ppc_pipe_ctrl_if #(.CNT_W(4))  b2 ();

  ppc_pipe_ctrl u0 (.clk(clk), .reset(rst), .bus(b0));

  ppc_pipe_ctrl #(.REDIRECT_BUBBLES(2)) u1 (.clk(clk), .reset(rst), .bus(b1));

  ppc_pipe_ctrl #(.RESET_PC(64'hFFFF_FFFF_FFFF_FFFC), .CNT_W(4)) u2 (.clk(clk), .reset(rst), .bus(b2));

  assign b1.stall_req       = b0.stall_req;
  assign b1.branch_taken_wb = b0.branch_taken_wb;
  assign b1.branch_target   = b0.branch_target;
  assign b1.st_en_wb        = b0.st_en_wb;
  assign b1.st_addr_wb      = b0.st_addr_wb;
  assign b1.halt_req        = b0.halt_req;

  assign b2.stall_req       = 1'b0;
  assign b2.branch_taken_wb = 1'b0;
  assign b2.branch_target   = '0;
  assign b2.st_en_wb        = 1'b0;
  assign b2.st_addr_wb      = '0;
  assign b2.halt_req        = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    b0.stall_req       = 1'b0;
    b0.branch_taken_wb = 1'b0;
    b0.branch_target   = '0;
    b0.st_en_wb        = 1'b0;
    b0.st_addr_wb      = '0;
    b0.halt_req        = 1'b0;
  endtask

  // Scoreboard: each instruction leaving u0's WB slot must be the next expected PC.
  always @(negedge clk) begin
    if (!rst && b0.valid_wb && (!b0.stall_req || b0.halt_req || b0.branch_taken_wb)) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL retire_unexpected: pc_wb %h retired, expected nothing", b0.pc_wb);
      end else begin
        mon_exp = exp_q.pop_front();
        if (b0.pc_wb !== mon_exp) begin
          errors++;
          $display("FAIL retire_pc: got %h expected %h", b0.pc_wb, mon_exp);
        end
      end
    end
  end

  initial begin
    clear_inputs();
    exp_q.push_back(64'h0);
    exp_q.push_back(64'h4);
    exp_q.push_back(64'h8);

    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_pc", b0.pc, 64'h0);
    chk("rst_valid_wb", {63'd0, b0.valid_wb}, 64'd0);
    chk("rst_halted", {63'd0, b0.halted}, 64'd0);
    chk("rst_cycle", 64'(b0.cycle_cnt), 64'd0);
    chk("rst_retired", 64'(b0.retired_cnt), 64'd0);
    chk("rst_pc_u2", b2.pc, 64'hFFFF_FFFF_FFFF_FFFC);

    for (int t = 1; t <= 36; t++) begin
      tick();
      clear_inputs();
      case (t)
        1: begin
          chk("c1_pc", b0.pc, 64'h4);
          chk("c1_cycle", 64'(b0.cycle_cnt), 64'd1);
          chk("c1_pc_wrap_u2", b2.pc, 64'h0);
        end
        3: begin
          chk("c3_pc", b0.pc, 64'hC);
          chk("c3_valid_wb", {63'd0, b0.valid_wb}, 64'd1);
          chk("c3_pc_wb", b0.pc_wb, 64'h0);
          chk("c3_retired", 64'(b0.retired_cnt), 64'd0);
        end
        4: chk("c4_retired", 64'(b0.retired_cnt), 64'd1);
        5: begin
          chk("c5_retired", 64'(b0.retired_cnt), 64'd2);
          b0.branch_taken_wb = 1'b1;
          b0.branch_target   = 64'h100;
        end
        6: begin
          chk("br_pc", b0.pc, 64'h100);
          chk("br_valids", {61'd0, b0.valid_d, b0.valid_e, b0.valid_wb}, 64'd0);
          chk("br_redirect", 64'(b0.redirect_cnt), 64'd1);
          chk("br_retired", 64'(b0.retired_cnt), 64'd3);
          chk("br_pc_u1", b1.pc, 64'h100);
          chk("br_redirect_u1", 64'(b1.redirect_cnt), 64'd1);
          exp_q.push_back(64'h100);
          exp_q.push_back(64'h104);
          exp_q.push_back(64'h108);
          exp_q.push_back(64'h110);
        end
        7: begin
          chk("br1_pc", b0.pc, 64'h104);
          chk("bub1_pc_u1", b1.pc, 64'h100);
          chk("bub1_valid_d_u1", {63'd0, b1.valid_d}, 64'd0);
        end
        8: chk("bub2_pc_u1", b1.pc, 64'h100);
        9: begin
          chk("bub_end_pc_u1", b1.pc, 64'h104);
          chk("bub_end_pc_d_u1", b1.pc_d, 64'h100);
          chk("cycle9_u2", 64'(b2.cycle_cnt), 64'd9);
          chk("pre_st_pc_e", b0.pc_e, 64'h104);
          b0.st_en_wb   = 1'b1;
          b0.st_addr_wb = 61'h20;
        end
        10: begin
          chk("st_e_pc", b0.pc, 64'h104);
          chk("st_e_valids", {61'd0, b0.valid_d, b0.valid_e, b0.valid_wb}, 64'd0);
          chk("st_e_redirect", 64'(b0.redirect_cnt), 64'd2);
          chk("st_e_retired", 64'(b0.retired_cnt), 64'd4);
        end
        13: begin
          chk("c13_pc_wb", b0.pc_wb, 64'h104);
          b0.st_en_wb   = 1'b1;
          b0.st_addr_wb = 61'h100;
        end
        14: begin
          chk("st_miss_pc", b0.pc, 64'h114);
          chk("st_miss_pc_wb", b0.pc_wb, 64'h108);
          chk("st_miss_valid_wb", {63'd0, b0.valid_wb}, 64'd1);
          chk("st_miss_redirect", 64'(b0.redirect_cnt), 64'd2);
          b0.st_en_wb   = 1'b1;
          b0.st_addr_wb = 61'h22;
        end
        15: begin
          chk("st_d_pc", b0.pc, 64'h110);
          chk("st_d_valid_d", {63'd0, b0.valid_d}, 64'd0);
          chk("st_d_redirect", 64'(b0.redirect_cnt), 64'd3);
          chk("st_d_retired", 64'(b0.retired_cnt), 64'd6);
        end
        18: begin
          chk("c18_pc_wb", b0.pc_wb, 64'h110);
          b0.stall_req = 1'b1;
        end
        19: b0.stall_req = 1'b1;
        20: begin
          chk("sat_cycle_u2", 64'(b2.cycle_cnt), 64'd15);
          b0.stall_req = 1'b1;
        end
        21: begin
          chk("stall_pc", b0.pc, 64'h11C);
          chk("stall_pc_d", b0.pc_d, 64'h118);
          chk("stall_pc_wb", b0.pc_wb, 64'h110);
          chk("stall_cycle", 64'(b0.cycle_cnt), 64'd21);
          chk("stall_retired", 64'(b0.retired_cnt), 64'd6);
          b0.stall_req       = 1'b1;
          b0.branch_taken_wb = 1'b1;
          b0.branch_target   = 64'h200;
        end
        22: begin
          chk("stall_br_pc", b0.pc, 64'h200);
          chk("stall_br_valid_wb", {63'd0, b0.valid_wb}, 64'd0);
          chk("stall_br_redirect", 64'(b0.redirect_cnt), 64'd4);
          chk("stall_br_retired", 64'(b0.retired_cnt), 64'd7);
          exp_q.push_back(64'h200);
        end
        25: begin
          chk("c25_pc_wb", b0.pc_wb, 64'h200);
          b0.halt_req        = 1'b1;
          b0.branch_taken_wb = 1'b1;
          b0.branch_target   = 64'h300;
        end
        26: begin
          chk("halt_halted", {63'd0, b0.halted}, 64'd1);
          chk("halt_pc", b0.pc, 64'h20C);
          chk("halt_valid_wb", {63'd0, b0.valid_wb}, 64'd0);
          chk("halt_retired", 64'(b0.retired_cnt), 64'd8);
        end
        36: begin
          chk("halt10_halted", {63'd0, b0.halted}, 64'd1);
          chk("halt10_pc", b0.pc, 64'h20C);
          chk("halt10_cycle", 64'(b0.cycle_cnt), 64'd26);
          chk("halt10_retired", 64'(b0.retired_cnt), 64'd8);
          chk("halt10_redirect", 64'(b0.redirect_cnt), 64'd4);
        end
        default: ;
      endcase
    end

    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rerst_pc", b0.pc, 64'h0);
    chk("rerst_halted", {63'd0, b0.halted}, 64'd0);
    chk("rerst_cycle", 64'(b0.cycle_cnt), 64'd0);
    chk("rerst_retired", 64'(b0.retired_cnt), 64'd0);
    chk("rerst_pc_u2", b2.pc, 64'hFFFF_FFFF_FFFF_FFFC);
    tick();
    chk("rerst_run_pc", b0.pc, 64'h4);
    chk("scoreboard_drain", 64'(exp_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
